// File: rtl/systolic_skew_feeder_if.sv
// Handshake bundle between a column-vector producer, the skew feeder and the
// systolic array edge. The feeder sits on the slave side.
interface systolic_skew_feeder_if #(
  parameter int DATA_BITS   = 8,
  parameter int MATRIX_SIZE = 8
);
  logic                             in_valid;
  logic                             in_ready;
  logic [MATRIX_SIZE*DATA_BITS-1:0] in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [MATRIX_SIZE*DATA_BITS-1:0] out_data;
  logic [MATRIX_SIZE-1:0]           out_lane_valid;
  logic                             out_first;
  logic                             out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane_valid, out_first, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane_valid, out_first, out_last
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Double-buffered tile feeder: loads MATRIX_SIZE x DEPTH tiles column by column
// into ping-pong banks and streams each one with a per-lane diagonal skew.
module systolic_skew_feeder #(
  parameter int DATA_BITS   = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int DEPTH       = 8,
  parameter int OUTPUT_SIZE = DEPTH + MATRIX_SIZE - 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 skew_mode,
  systolic_skew_feeder_if.slave bus
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [CW-1:0] WC_LAST = CW'(DEPTH - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OUTPUT_SIZE - 1);

  logic [DATA_BITS-1:0] bank_q [2][DEPTH][MATRIX_SIZE];
  logic [1:0]    full_q, full_d;
  logic          wb_q, wb_d, rb_q, rb_d, m_q, m_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [TW-1:0] t_q, t_d;
  logic          wr_fire, rd_fire, mode_eff;
  logic [MATRIX_SIZE*DATA_BITS-1:0] data_c;
  logic [MATRIX_SIZE-1:0]           lane_v_c;
  int            lane_delay, lane_col;

  assign wr_fire  = bus.in_valid & ~full_q[wb_q] & ~clear;
  assign rd_fire  = full_q[rb_q] & bus.out_ready & ~clear;
  // Until the first beat of a frame is taken the mode input is transparent.
  assign mode_eff = (t_q == '0) ? skew_mode : m_q;

  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wc_d   = wc_q;
    t_d    = t_q;
    m_d    = mode_eff;
    if (wr_fire) begin
      if (wc_q == WC_LAST) begin
        full_d[wb_q] = 1'b1;
        wc_d         = '0;
        wb_d         = ~wb_q;
      end else begin
        wc_d = wc_q + CW'(1);
      end
    end
    if (rd_fire) begin
      if (t_q == T_LAST) begin
        full_d[rb_q] = 1'b0;
        t_d          = '0;
        rb_d         = ~rb_q;
      end else begin
        t_d = t_q + TW'(1);
      end
    end
    if (clear) begin
      full_d = '0;
      wb_d   = 1'b0;
      rb_d   = 1'b0;
      wc_d   = '0;
      t_d    = '0;
      m_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wc_q   <= '0;
      t_q    <= '0;
      m_q    <= 1'b0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wc_q   <= wc_d;
      t_q    <= t_d;
      m_q    <= m_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        bank_q[wb_q][wc_q][i] <= bus.in_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Lane i shows column t - delay(i) of the read bank, zero outside the tile.
  always_comb begin
    data_c     = '0;
    lane_v_c   = '0;
    lane_delay = 0;
    lane_col   = 0;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      lane_delay = mode_eff ? (MATRIX_SIZE - 1 - i) : i;
      lane_col   = int'(t_q) - lane_delay;
      if (full_q[rb_q] && lane_col >= 0 && lane_col < DEPTH) begin
        lane_v_c[i]                       = 1'b1;
        data_c[i*DATA_BITS +: DATA_BITS]  = bank_q[rb_q][lane_col[CW-1:0]][i];
      end
    end
  end

  assign bus.in_ready       = ~full_q[wb_q];
  assign bus.out_valid      = full_q[rb_q];
  assign bus.out_data       = data_c;
  assign bus.out_lane_valid = lane_v_c;
  assign bus.out_first      = full_q[rb_q] & (t_q == '0);
  assign bus.out_last       = full_q[rb_q] & (t_q == T_LAST);
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomised and directed bench for the skew feeder (8x8 and 4x3 builds),
// checked against a tile-queue reference model.
module tb_systolic_skew_feeder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic skew_mode = 1'b0;
  logic clear_s = 1'b0;
  logic skew_s = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  systolic_skew_feeder_if #(.DATA_BITS(8), .MATRIX_SIZE(8)) bif ();
  systolic_skew_feeder_if #(.DATA_BITS(8), .MATRIX_SIZE(4)) sif ();

  systolic_skew_feeder #(.DATA_BITS(8), .MATRIX_SIZE(8), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .clear(clear), .skew_mode(skew_mode), .bus(bif.slave));
  systolic_skew_feeder #(.DATA_BITS(8), .MATRIX_SIZE(4), .DEPTH(3)) dut_s (
    .clock(clock), .reset(reset), .clear(clear_s), .skew_mode(skew_s), .bus(sif.slave));

  always #5 clock = ~clock;

  // reference model state for the 8x8 build
  logic [63:0] full_cols[$];
  logic [63:0] pend[$];
  int          mt = 0;
  bit          mm = 1'b0;
  logic [63:0] obs_data;
  logic [7:0]  obs_mask;
  logic        obs_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic void exp_out(input logic [63:0] cols [8], input int ms, input int depth,
                                  input bit mode, input int t,
                                  output logic [63:0] data, output logic [7:0] mask);
    int d, k;
    data = '0;
    mask = '0;
    for (int ln = 0; ln < ms; ln++) begin
      d = mode ? (ms - 1 - ln) : ln;
      k = t - d;
      if (k >= 0 && k < depth) begin
        data[ln*8 +: 8] = cols[k][ln*8 +: 8];
        mask[ln] = 1'b1;
      end
    end
  endfunction

  function automatic logic [63:0] ramp_col(input int c);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(i*8 + c);
    return v;
  endfunction

  task automatic model_reset();
    full_cols.delete();
    pend.delete();
    mt = 0;
    mm = 1'b0;
  endtask

  // One clock of the 8x8 build: drive, check against the model, advance the model.
  task automatic cyc(input bit iv, input logic [63:0] id, input bit ordy, input bit sk, input bit clr);
    logic [63:0] cols [8];
    logic [63:0] ed;
    logic [7:0]  em;
    bit eiv, eov, mode;
    int nfull;
    bif.in_valid  = iv;
    bif.in_data   = id;
    bif.out_ready = ordy;
    skew_mode     = sk;
    clear         = clr;
    #1;
    nfull = full_cols.size() / 8;
    eiv   = (nfull < 2);
    eov   = (nfull > 0);
    mode  = (mt == 0) ? sk : mm;
    for (int c = 0; c < 8; c++) cols[c] = eov ? full_cols[c] : 64'd0;
    exp_out(cols, 8, 8, mode, mt, ed, em);
    if (!eov) begin
      ed = '0;
      em = '0;
    end
    chk("in_ready", bif.in_ready, eiv);
    chk("out_valid", bif.out_valid, eov);
    chk("out_data", bif.out_data, ed);
    chk("lane_valid", bif.out_lane_valid, em);
    chk("out_first", bif.out_first, eov && mt == 0);
    chk("out_last", bif.out_last, eov && mt == 14);
    obs_data = bif.out_data;
    obs_mask = bif.out_lane_valid;
    obs_last = bif.out_last;
    if (clr) begin
      model_reset();
    end else begin
      if (eov && ordy) begin
        if (mt == 0) mm = sk;
        if (mt == 14) begin
          for (int c = 0; c < 8; c++) void'(full_cols.pop_front());
          mt = 0;
        end else begin
          mt++;
        end
      end
      if (iv && eiv) begin
        pend.push_back(id);
        if (pend.size() == 8) begin
          foreach (pend[j]) full_cols.push_back(pend[j]);
          pend.delete();
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic load_ramp(input bit sk);
    for (int c = 0; c < 8; c++) cyc(1'b1, ramp_col(c), 1'b1, sk, 1'b0);
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    chk("arst_in_ready", bif.in_ready, 1'b1);
    chk("arst_out_valid", bif.out_valid, 1'b0);
    chk("arst_out_data", bif.out_data, 64'd0);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] scols [8];
    logic [63:0] ed;
    logic [7:0]  em;
    bif.in_valid = 1'b0; bif.in_data = '0; bif.out_ready = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", bif.in_ready, 1'b1);
    chk("rst_out_valid", bif.out_valid, 1'b0);
    chk("rst_out_data", bif.out_data, 64'd0);
    chk("rst_lane_valid", bif.out_lane_valid, 8'd0);
    chk("rst_first_last", {bif.out_first, bif.out_last}, 2'b00);
    reset = 1'b1;
    @(negedge clock);

    // basic frame, mode 0
    load_ramp(1'b0);
    for (int b = 0; b < 15; b++) begin
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
      if (b == 0) begin
        chk("m0_t0_mask", obs_mask, 8'h01);
        chk("m0_t0_lane0", obs_data[7:0], 8'd0);
      end
      if (b == 7) chk("m0_t7_l7_l0", {obs_data[63:56], obs_data[7:0]}, {8'd56, 8'd7});
      if (b == 14) chk("m0_t14", {obs_mask, obs_data[63:56], 7'd0, obs_last}, {8'h80, 8'd63, 8'h01});
    end
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // mode 1, skew_mode toggled after the first beat
    load_ramp(1'b1);
    for (int b = 0; b < 15; b++) begin
      cyc(1'b0, 64'd0, 1'b1, (b == 0) ? 1'b1 : 1'($urandom), 1'b0);
      if (b == 0) chk("m1_t0", {obs_mask, obs_data[63:56]}, {8'h80, 8'd56});
      if (b == 14) chk("m1_t14", {obs_mask, obs_data[7:0]}, {8'h01, 8'd7});
    end

    // backpressure at t=5 for three cycles
    load_ramp(1'b0);
    for (int n = 0; n < 18; n++) cyc(1'b0, 64'd0, !(n >= 5 && n < 8), 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // ping-pong: continuous writes, array always ready
    for (int n = 0; n < 40; n++) cyc(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // mid-frame clear, then a fresh tile
    load_ramp(1'b0);
    for (int n = 0; n < 4; n++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 64'd1, 1'b1, 1'b0, 1'b1);
    load_ramp(1'b0);
    for (int n = 0; n < 16; n++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // async reset at t=4, then a fresh tile
    load_ramp(1'b1);
    for (int n = 0; n < 4; n++) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    async_reset();
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    load_ramp(1'b0);
    for (int n = 0; n < 16; n++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // random traffic
    for (int n = 0; n < 800; n++)
      cyc(($urandom % 10) < 7, {$urandom, $urandom}, ($urandom % 10) < 7,
          1'($urandom), ($urandom % 100) == 0);

    // 4-lane, depth-3 build: 6-beat frames in both modes
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 8; c++) scols[c] = '0;
      skew_s = 1'(m);
      for (int c = 0; c < 3; c++) begin
        scols[c] = {32'd0, $urandom};
        sif.in_valid = 1'b1;
        sif.in_data  = scols[c][31:0];
        sif.out_ready = 1'b1;
        #1;
        chk("s_in_ready", sif.in_ready, 1'b1);
        @(negedge clock);
      end
      sif.in_valid = 1'b0;
      for (int t = 0; t < 6; t++) begin
        #1;
        exp_out(scols, 4, 3, 1'(m), t, ed, em);
        chk("s_out_valid", sif.out_valid, 1'b1);
        chk("s_out_data", {32'd0, sif.out_data}, ed);
        chk("s_lane_valid", {4'd0, sif.out_lane_valid}, em);
        chk("s_first_last", {sif.out_first, sif.out_last}, {t == 0, t == 5});
        if (t == 5 && m == 0) begin
          chk("s_t5_lanes012", {40'd0, sif.out_data[23:0]}, 64'd0);
          chk("s_t5_lane3", {56'd0, sif.out_data[31:24]}, {56'd0, scols[2][31:24]});
        end
        @(negedge clock);
      end
      #1;
      chk("s_end_valid", sif.out_valid, 1'b0);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
